// File: rtl/pre_arbiter_queue_if.sv
// rtl/pre_arbiter_queue_if.sv - descriptor ingress, arbiter handshake and per-port queue streams
interface pre_arbiter_queue_if #(
    parameter int pPORT_NUM   = 4,
    parameter int pFIFO_WIDTH = 16
);
    localparam int PORT_W = $clog2(pPORT_NUM);

    logic                               i_w_permition;
    logic [PORT_W-1:0]                  i_port_num;
    logic [pFIFO_WIDTH-1:0]             i_length_ptr;
    logic                               o_request;
    logic                               i_grant;
    logic                               o_busy;
    logic                               o_drop;
    logic [pPORT_NUM*pFIFO_WIDTH-1:0]   o_q_data;
    logic [pPORT_NUM-1:0]               o_q_valid;
    logic [pPORT_NUM-1:0]               i_q_ready;
    logic [pPORT_NUM-1:0]               o_q_full;

    modport master (
        output i_w_permition, i_port_num, i_length_ptr, i_grant, i_q_ready,
        input  o_request, o_busy, o_drop, o_q_data, o_q_valid, o_q_full
    );

    modport slave (
        input  i_w_permition, i_port_num, i_length_ptr, i_grant, i_q_ready,
        output o_request, o_busy, o_drop, o_q_data, o_q_valid, o_q_full
    );
endinterface

// File: rtl/pre_arbiter_queue.sv
// rtl/pre_arbiter_queue.sv - ingress pre-arbiter feeding per-destination descriptor FIFOs
module pre_arbiter_queue #(
    parameter int pPORT_NUM     = 4,
    parameter int pFIFO_WIDTH   = 16,
    parameter int pQ_DEPTH      = 4,
    parameter int pSELF_PORT    = 0,
    parameter int pDROP_ON_FULL = 0
) (
    input  logic               iclk,
    input  logic               i_rst_n,
    pre_arbiter_queue_if.slave bus
);
    localparam int PW = $clog2(pPORT_NUM);
    localparam int AW = $clog2(pQ_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, PUSH} state_t;

    state_t                   state_q;
    logic                     request_q;
    logic                     busy_q;
    logic                     drop_q;
    logic [PW-1:0]            port_q;
    logic [pFIFO_WIDTH-1:0]   ptr_q;

    logic [pFIFO_WIDTH-1:0]   mem_q  [pPORT_NUM][pQ_DEPTH];
    logic [AW-1:0]            wptr_q [pPORT_NUM];
    logic [AW-1:0]            rptr_q [pPORT_NUM];
    logic [CW-1:0]            cnt_q  [pPORT_NUM];
    logic [AW-1:0]            wptr_d [pPORT_NUM];
    logic [AW-1:0]            rptr_d [pPORT_NUM];
    logic [CW-1:0]            cnt_d  [pPORT_NUM];

    logic [pPORT_NUM-1:0]             valid;
    logic [pPORT_NUM-1:0]             full;
    logic [pPORT_NUM-1:0]             pop;
    logic [pPORT_NUM-1:0]             push;
    logic [pPORT_NUM*pFIFO_WIDTH-1:0] q_data;
    logic                             dest_bad;
    logic                             tgt_full;
    logic                             tgt_pop;
    logic                             push_ok;

    always_comb begin
        valid  = '0;
        full   = '0;
        pop    = '0;
        q_data = '0;
        for (int k = 0; k < pPORT_NUM; k++) begin
            valid[k] = (cnt_q[k] != '0);
            full[k]  = (cnt_q[k] == CW'(pQ_DEPTH));
            pop[k]   = valid[k] & bus.i_q_ready[k];
            q_data[k*pFIFO_WIDTH +: pFIFO_WIDTH] = mem_q[k][rptr_q[k]];
        end
    end

    // A pop on the target queue in the push cycle frees the slot we are about to fill.
    always_comb begin
        dest_bad = (int'(port_q) >= pPORT_NUM) || (int'(port_q) == pSELF_PORT);
        tgt_full = 1'b0;
        tgt_pop  = 1'b0;
        for (int k = 0; k < pPORT_NUM; k++) begin
            if (PW'(k) == port_q) begin
                tgt_full = full[k];
                tgt_pop  = pop[k];
            end
        end
        push_ok = (state_q == PUSH) && !dest_bad && (!tgt_full || tgt_pop);
        push = '0;
        for (int k = 0; k < pPORT_NUM; k++) begin
            push[k]   = push_ok && (PW'(k) == port_q);
            wptr_d[k] = wptr_q[k] + AW'(push[k]);
            rptr_d[k] = rptr_q[k] + AW'(pop[k]);
            cnt_d[k]  = cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
        end
    end

    always_ff @(posedge iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            request_q <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
            port_q    <= '0;
            ptr_q     <= '0;
        end else begin
            drop_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_w_permition) begin
                        state_q   <= REQ;
                        request_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.i_grant) begin
                        port_q    <= bus.i_port_num;
                        ptr_q     <= bus.i_length_ptr;
                        state_q   <= PUSH;
                        request_q <= 1'b0;
                    end
                end
                PUSH: begin
                    if (dest_bad) begin
                        drop_q  <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (!tgt_full || tgt_pop) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (pDROP_ON_FULL != 0) begin
                        drop_q  <= 1'b1;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    request_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge iclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < pPORT_NUM; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
                cnt_q[k]  <= '0;
                for (int e = 0; e < pQ_DEPTH; e++) begin
                    mem_q[k][e] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < pPORT_NUM; k++) begin
                if (push[k]) begin
                    mem_q[k][wptr_q[k]] <= ptr_q;
                end
                wptr_q[k] <= wptr_d[k];
                rptr_q[k] <= rptr_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    assign bus.o_request = request_q;
    assign bus.o_busy    = busy_q;
    assign bus.o_drop    = drop_q;
    assign bus.o_q_data  = q_data;
    assign bus.o_q_valid = valid;
    assign bus.o_q_full  = full;
endmodule
